// File: rtl/seq_detector_pkg.sv
// Shared definitions for the parametrised serial pattern detector:
// state encoding and the helper that builds the length-qualified compare mask.
package seq_detector_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Low `len` bits set; wide enough for the largest supported pattern (32 bits).
  function automatic logic [31:0] len_mask(input logic [5:0] len);
    logic [63:0] m;
    m = (64'd1 << len) - 64'd1;
    return m[31:0];
  endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/seq_detector_param.sv
// Serial detector for a runtime-loaded pattern of 1..MAX_LEN bits with
// overlapping / non-overlapping match modes and a saturating match counter.
module seq_detector_param
  import seq_detector_pkg::*;
#(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 8,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [MAX_LEN-1:0] pattern_in,
  input  logic [LEN_W-1:0]   len_in,
  input  logic               overlap,
  input  logic               w_valid,
  input  logic               w,
  input  logic               clear_count,
  output logic               armed,
  output logic               match,
  output logic [LEN_W-1:0]   progress,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  state_t             state_q;
  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic [MAX_LEN-2:0] hist_q;
  logic [LEN_W-1:0]   prog_q;
  logic               match_q;
  logic               cfg_err_q;

  logic               len_legal;
  logic               sample;
  logic [MAX_LEN-1:0] hist_d;
  logic [LEN_W:0]     seen_ext;
  logic [LEN_W-1:0]   seen;
  logic [MAX_LEN-1:0] mask;
  logic               hit;

  // Stream handshake: w is consumed on every rising edge where w_valid is high,
  // the detector is in RUN and load is low; there is no back-pressure.
  always_comb begin
    len_legal = (len_in != '0) && ({1'b0, len_in} <= (LEN_W + 1)'(MAX_LEN));
    sample    = (state_q == RUN) && w_valid && !load;
    hist_d    = {hist_q, w};
    seen_ext  = {1'b0, prog_q} + (LEN_W + 1)'(1);
    seen      = (seen_ext > {1'b0, len_q}) ? len_q : seen_ext[LEN_W-1:0];
    mask      = MAX_LEN'(len_mask(6'(len_q)));
    hit       = sample && (seen == len_q) && ((hist_d & mask) == (pattern_q & mask));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pattern_q <= '0;
      len_q     <= '0;
      hist_q    <= '0;
      prog_q    <= '0;
      match_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      match_q   <= 1'b0;
      cfg_err_q <= 1'b0;
      if (load) begin
        // A load always wins over a same-cycle data bit, which is dropped.
        if (len_legal) begin
          state_q   <= RUN;
          pattern_q <= pattern_in;
          len_q     <= len_in;
          hist_q    <= '0;
          prog_q    <= '0;
        end else begin
          cfg_err_q <= 1'b1;
        end
      end else if (sample) begin
        hist_q  <= hist_d[MAX_LEN-2:0];
        match_q <= hit;
        if (hit) begin
          prog_q <= overlap ? len_q : '0;
        end else begin
          prog_q <= seen;
        end
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (hit),
    .clr   (clear_count),
    .count (match_count)
  );

  assign armed    = (state_q == RUN);
  assign match    = match_q;
  assign progress = prog_q;
  assign cfg_err  = cfg_err_q;

endmodule
